// File: rtl/dwt_haar_stage_if.sv
// Stream bundle for dwt_haar_stage: a sample input channel and a coefficient-pair output channel.
// Both channels use valid/ready. A beat transfers on a rising clock edge when valid & ready.
// The sender holds its data and valid stable until ready is seen; ready may depend on valid.
interface dwt_haar_stage_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] sample_in;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       approx_out;
  logic [31:0]       detail_out;
  logic              coeff_last;
  logic              frame_done;

  modport slave (
    input  in_valid, sample_in, out_ready,
    output in_ready, out_valid, approx_out, detail_out, coeff_last, frame_done
  );

  modport master (
    output in_valid, sample_in, out_ready,
    input  in_ready, out_valid, approx_out, detail_out, coeff_last, frame_done
  );
endinterface

// File: rtl/dwt_haar_stage.sv
// Single-level Haar DWT stage: pairs consecutive samples into approx/detail coefficients.
// Optional macro DWT_ROUND_EN rounds half toward +inf instead of flooring.
module dwt_haar_stage #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  dwt_haar_stage_if.slave     bus,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    S_EVEN = 2'd0,
    S_ODD  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam int PAIRS = FRAME_LEN / 2;
  localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(PAIRS - 1);
  // Two guard bits: one for the sum/difference, one so rounding of the extreme difference cannot wrap.
  localparam int AW = DATA_W + 2;
`ifdef DWT_ROUND_EN
  localparam logic signed [AW-1:0] RND = {{(AW-1){1'b0}}, 1'b1};
`else
  localparam logic signed [AW-1:0] RND = '0;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] x0_q, x0_d;
  logic [31:0]       approx_q, approx_d;
  logic [31:0]       detail_q, detail_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;

  logic              out_valid;
  logic              in_ready;
  logic              in_xfer;
  logic              out_xfer;
  logic signed [AW-1:0] x0_ext, x1_ext, sum_w, dif_w;

  assign out_valid = (state_q == S_OUT);
  assign in_ready  = rst_n & en & ((state_q != S_OUT) | bus.out_ready);
  assign in_xfer   = bus.in_valid & in_ready;
  assign out_xfer  = out_valid & bus.out_ready;

  assign x0_ext = {{2{x0_q[DATA_W-1]}}, x0_q};
  assign x1_ext = {{2{bus.sample_in[DATA_W-1]}}, bus.sample_in};
  assign sum_w  = x0_ext + x1_ext + RND;
  assign dif_w  = x0_ext - x1_ext + RND;

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    approx_d = approx_q;
    detail_d = detail_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    case (state_q)
      S_EVEN: begin
        if (in_xfer) begin
          x0_d    = bus.sample_in;
          state_d = S_ODD;
        end
      end
      S_ODD: begin
        if (in_xfer) begin
          approx_d = 32'(sum_w >>> 1);
          detail_d = 32'(dif_w >>> 1);
          state_d  = S_OUT;
        end
      end
      S_OUT: begin
        if (out_xfer) begin
          cnt_d  = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
          done_d = (cnt_q == LAST_CNT);
          // A new even sample may arrive in the same cycle the pair leaves.
          if (in_xfer) begin
            x0_d    = bus.sample_in;
            state_d = S_ODD;
          end else begin
            state_d = S_EVEN;
          end
        end
      end
      default: state_d = S_EVEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      state_q  <= S_EVEN;
      x0_q     <= '0;
      approx_q <= '0;
      detail_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      approx_q <= approx_d;
      detail_q <= detail_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.approx_out = approx_q;
  assign bus.detail_out = detail_q;
  assign bus.coeff_last = out_valid & (cnt_q == LAST_CNT);
  assign bus.frame_done = done_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_dwt_haar_stage.sv
// Directed bench for dwt_haar_stage with an expected-pair queue checked by a separate monitor.
module tb_dwt_haar_stage;
  localparam int DW = 16;
  localparam int W  = 65;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] dbg_state;

  dwt_haar_stage_if #(.DATA_W(DW)) ifc ();

  dwt_haar_stage #(.DATA_W(DW), .FRAME_LEN(128)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .bus         (ifc.slave),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic last_hs = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic push(input logic last, input int a, input int d);
    exp_q.push_back({last, 32'(a), 32'(d)});
  endtask

  // driver: present one sample and hold it until it is accepted
  task automatic send_sample(input int v);
    int budget = 50;
    ifc.in_valid  = 1'b1;
    ifc.sample_in = DW'(v);
    while (!ifc.in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!ifc.in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL in_accept_timeout: sample %0d never accepted", v);
    end else begin
      @(posedge clk);
    end
    #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic send_pair(input int a, input int b, input logic last, input int ea, input int ed);
    push(last, ea, ed);
    send_sample(a);
    send_sample(b);
  endtask

  task automatic wait_drain();
    int budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d pairs still expected, 0 required", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic exp_done;
    exp_done = last_hs;
    last_hs  = 1'b0;
    if (ifc.out_valid && ifc.out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pair: got approx=%0d detail=%0d, no pair expected",
                 $signed(ifc.approx_out), $signed(ifc.detail_out));
      end else begin
        e = exp_q.pop_front();
        last_hs = e[64];
        if ({ifc.coeff_last, ifc.approx_out, ifc.detail_out} !== e) begin
          n_err++;
          $display("FAIL pair: got last=%0b approx=%0d detail=%0d, expected last=%0b approx=%0d detail=%0d",
                   ifc.coeff_last, $signed(ifc.approx_out), $signed(ifc.detail_out),
                   e[64], $signed(e[63:32]), $signed(e[31:0]));
        end
      end
    end
    if (exp_done || ifc.frame_done) begin
      n_vec++;
      if (ifc.frame_done !== exp_done) begin
        n_err++;
        $display("FAIL frame_done: got %0b, expected %0b", ifc.frame_done, exp_done);
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    en            = 1'b1;
    ifc.in_valid  = 1'b1;
    ifc.sample_in = DW'(5);
    ifc.out_ready = 1'b1;

    // 1. reset with in_valid high
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(ifc.in_ready), 32'd0);
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_approx", ifc.approx_out, 32'd0);
    check("rst_detail", ifc.detail_out, 32'd0);
    check("rst_last", 32'(ifc.coeff_last), 32'd0);
    check("rst_done", 32'(ifc.frame_done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    ifc.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(ifc.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 2. basic pair and one-cycle out_valid
    send_pair(10, 4, 1'b0, 7, 3);
    @(negedge clk);
    check("basic_valid_rise", 32'(ifc.out_valid), 32'd1);
    @(negedge clk);
    check("basic_valid_fall", 32'(ifc.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // 3. signed extremes and rounding cases
    send_pair(-32768, -32768, 1'b0, -32768, 0);
`ifdef DWT_ROUND_EN
    send_pair(32767, -32768, 1'b0, 0, 32768);
    send_pair(3, 0, 1'b0, 2, 2);
    send_pair(-3, 0, 1'b0, -1, -1);
`else
    send_pair(32767, -32768, 1'b0, -1, 32767);
    send_pair(3, 0, 1'b0, 1, 1);
    send_pair(-3, 0, 1'b0, -2, -2);
`endif
    wait_drain();
    @(posedge clk);
    #1;

    // 4. backpressure with the next even sample waiting
    ifc.out_ready = 1'b0;
    send_pair(100, -50, 1'b0, 25, 75);
    ifc.in_valid  = 1'b1;
    ifc.sample_in = DW'(7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(ifc.in_ready), 32'd0);
      check("bp_out_valid", 32'(ifc.out_valid), 32'd1);
      check("bp_approx", ifc.approx_out, 32'd25);
      check("bp_detail", ifc.detail_out, 32'd75);
    end
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(ifc.in_ready), 32'd1);
    push(1'b0, 4, 3);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    send_sample(1);
    wait_drain();

    // 5. full frame from a clean counter, plus first pair of the next frame
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 65; k++) begin
`ifdef DWT_ROUND_EN
      push(k == 63, ((2 * k) % 128) + 1, 0);
`else
      push(k == 63, (2 * k) % 128, -1);
`endif
      send_sample((2 * k) % 128);
      send_sample((2 * k + 1) % 128);
    end
    wait_drain();

    // 6. mid-frame flush discards the held sample and restarts the count
    send_pair(10, 20, 1'b0, 15, -5);
    send_sample(99);
    wait_drain();
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("flush_in_ready", 32'(ifc.in_ready), 32'd0);
    check("flush_state", 32'(dbg_state), 32'd0);
    check("flush_out_valid", 32'(ifc.out_valid), 32'd0);
    en = 1'b1;
    @(posedge clk);
    #1;
    send_pair(8, 2, 1'b0, 5, 3);
    for (int k = 0; k < 63; k++) begin
      send_pair(k, k, k == 62, k, 0);
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, completion required");
    $fatal(1, "watchdog expired");
  end

endmodule
